// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - key inputs and control outputs of the stopwatch front end
interface stopwatch_ctrl_if;
  logic KEY_SS;
  logic KEY_CLR;
  logic EN1HZ;
  logic CLR;
  logic RUNNING;

  modport master (
    output KEY_SS,
    output KEY_CLR,
    input  EN1HZ,
    input  CLR,
    input  RUNNING
  );

  modport slave (
    input  KEY_SS,
    input  KEY_CLR,
    output EN1HZ,
    output CLR,
    output RUNNING
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - key debounce, start/stop FSM and 1 Hz prescaler
module stopwatch_ctrl #(
  parameter int DIV        = 50_000_000,
  parameter int DEB_CYCLES = 1_000_000
) (
  input logic             CLK,
  input logic             RST,
  stopwatch_ctrl_if.slave sw
);

  localparam int PW = $clog2(DIV);
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam logic [PW-1:0] P_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0] D_LAST = DW'(DEB_CYCLES - 1);

  typedef enum logic {ST_STOP, ST_RUN} state_t;

  // bit 0 = START/STOP, bit 1 = CLEAR
  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    stable;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];

  state_t        state;
  state_t        state_nxt;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_nxt;
  logic          en_nxt;
  logic          clr_nxt;
  logic          en_q;
  logic          clr_q;

  assign raw = {sw.KEY_CLR, sw.KEY_SS};

  // A press pulse is emitted exactly when stable falls, i.e. stable was 1 at acceptance
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1      <= 2'b11;
      sync2      <= 2'b11;
      stable     <= 2'b11;
      press      <= 2'b00;
      deb_cnt[0] <= '0;
      deb_cnt[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 2; i++) begin
        press[i] <= 1'b0;
        if (sync2[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == D_LAST) begin
          stable[i]  <= sync2[i];
          deb_cnt[i] <= '0;
          press[i]   <= stable[i];
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= ST_STOP;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (press[1])      state_nxt = ST_STOP;
    else if (press[0]) state_nxt = (state == ST_RUN) ? ST_STOP : ST_RUN;
  end

  // Terminal count is judged on the current state, so a stop in the same cycle still fires EN1HZ
  always_comb begin
    en_nxt    = 1'b0;
    clr_nxt   = press[1];
    presc_nxt = presc;
    if (press[1]) begin
      presc_nxt = '0;
    end else if (state == ST_RUN) begin
      if (presc == P_LAST) begin
        presc_nxt = '0;
        en_nxt    = 1'b1;
      end else begin
        presc_nxt = presc + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      presc <= '0;
      en_q  <= 1'b0;
      clr_q <= 1'b0;
    end else begin
      presc <= presc_nxt;
      en_q  <= en_nxt;
      clr_q <= clr_nxt;
    end
  end

  assign sw.EN1HZ   = en_q;
  assign sw.CLR     = clr_q;
  assign sw.RUNNING = (state == ST_RUN);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - scoreboard bench for stopwatch_ctrl with DIV=10, DEB_CYCLES=4
module tb_stopwatch_ctrl;

  typedef struct packed {
    int   cyc;
    logic en;
    logic clr;
    logic run;
  } ev_t;

  logic CLK;
  logic RST;
  int   cyc;
  int   checks;
  int   errors;
  ev_t  exp_q[$];
  logic run_prev;

  stopwatch_ctrl_if sw ();

  stopwatch_ctrl #(.DIV(10), .DEB_CYCLES(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .sw  (sw.slave)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  task automatic push(input int c, input logic en, input logic clr, input logic run);
    ev_t e;
    e.cyc = c; e.en = en; e.clr = clr; e.run = run;
    exp_q.push_back(e);
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) @(negedge CLK);
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    checks = checks + 1;
    if (act !== req) begin
      errors = errors + 1;
      $display("FAIL %s got=%b expected=%b at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic check_outputs_low(input string tag);
    check_bit({tag, "_en1hz"},   sw.EN1HZ,   1'b0);
    check_bit({tag, "_clr"},     sw.CLR,     1'b0);
    check_bit({tag, "_running"}, sw.RUNNING, 1'b0);
  endtask

  // Monitor: any pulse or RUNNING change is an output event to be matched against the queue
  initial run_prev = 1'b0;
  always @(negedge CLK) begin
    ev_t e;
    if (sw.EN1HZ === 1'b1 || sw.CLR === 1'b1 || sw.RUNNING !== run_prev) begin
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        errors = errors + 1;
        $display("FAIL unexpected_event cyc=%0d en=%b clr=%b run=%b", cyc, sw.EN1HZ, sw.CLR, sw.RUNNING);
      end else begin
        e = exp_q.pop_front();
        if (e.cyc != cyc || e.en !== sw.EN1HZ || e.clr !== sw.CLR || e.run !== sw.RUNNING) begin
          errors = errors + 1;
          $display("FAIL event got cyc=%0d en=%b clr=%b run=%b expected cyc=%0d en=%b clr=%b run=%b",
                   cyc, sw.EN1HZ, sw.CLR, sw.RUNNING, e.cyc, e.en, e.clr, e.run);
        end
      end
    end
    run_prev = sw.RUNNING;
  end

  initial begin
    int t, r, d, e, f, g, h;
    checks     = 0;
    errors     = 0;
    sw.KEY_SS  = 1'b1;
    sw.KEY_CLR = 1'b1;
    RST        = 1'b1;
    #1 RST = 1'b0;
    #1 check_outputs_low("reset");
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (100) @(negedge CLK);

    repeat (5) begin
      sw.KEY_SS = 1'b0;
      repeat (3) @(negedge CLK);
      sw.KEY_SS = 1'b1;
      repeat (2) @(negedge CLK);
    end
    repeat (20) @(negedge CLK);

    t = cyc;
    r = t + 7;
    sw.KEY_SS = 1'b0;
    push(r,      1'b0, 1'b0, 1'b1);
    push(r + 10, 1'b1, 1'b0, 1'b1);
    push(r + 20, 1'b1, 1'b0, 1'b1);
    push(r + 30, 1'b1, 1'b0, 1'b1);
    push(r + 36, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge CLK);
    sw.KEY_SS = 1'b1;

    // stop lands with the prescaler at 6
    d = r + 29;
    wait_until(d);
    sw.KEY_SS = 1'b0;
    repeat (10) @(negedge CLK);
    sw.KEY_SS = 1'b1;

    e = d + 60;
    wait_until(e);
    sw.KEY_SS = 1'b0;
    push(e + 7,  1'b0, 1'b0, 1'b1);
    push(e + 11, 1'b1, 1'b0, 1'b1);
    push(e + 21, 1'b1, 1'b0, 1'b1);
    push(e + 25, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge CLK);
    sw.KEY_SS = 1'b1;

    f = e + 18;
    wait_until(f);
    sw.KEY_CLR = 1'b0;
    repeat (10) @(negedge CLK);
    sw.KEY_CLR = 1'b1;

    g = f + 30;
    wait_until(g);
    sw.KEY_SS  = 1'b0;
    sw.KEY_CLR = 1'b0;
    push(g + 7, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge CLK);
    sw.KEY_SS  = 1'b1;
    sw.KEY_CLR = 1'b1;

    // restart after clear must see a full DIV period, then reset at prescaler 7
    h = g + 30;
    wait_until(h);
    sw.KEY_SS = 1'b0;
    push(h + 7,  1'b0, 1'b0, 1'b1);
    push(h + 17, 1'b1, 1'b0, 1'b1);
    push(h + 25, 1'b0, 1'b0, 1'b0);
    repeat (10) @(negedge CLK);
    sw.KEY_SS = 1'b1;
    wait_until(h + 24);
    #2 RST = 1'b0;
    #1 check_outputs_low("async_reset");
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (30) @(negedge CLK);

    checks = checks + 1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL missing_events got=%0d pending expected=0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Front-end control stage for the 60-second seven-segment counter.
- Synchronises and debounces two raw push-buttons, START/STOP and CLEAR, and runs a start/stop state machine.
- Produces the 1 Hz count-enable pulse, a one-cycle clear pulse and a running flag. The downstream counter consumes these in place of its free-running enable.
- Prescaler phase is retained across pause/resume, so the block behaves as a stopwatch.

Parameters:
- DIV, 50_000_000, clock cycles per EN1HZ period (50 MHz → 1 Hz); minimum 2.
- DEB_CYCLES, 1_000_000, cycles a synchronised key level must persist before it is accepted (20 ms at 50 MHz); minimum 1.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  reset, asynchronous assert, active-low (0 = reset).
- KEY_SS  in  1  raw START/STOP button, active-low (0 = pressed), asynchronous to CLK.
- KEY_CLR  in  1  raw CLEAR button, active-low, asynchronous to CLK.
- EN1HZ  out  1  one-cycle pulse once per DIV cycles while running.
- CLR  out  1  one-cycle synchronous clear pulse for the downstream counter.
- RUNNING  out  1  1 = RUN state.

Behaviour:
- Reset (RST=0) forces, immediately and asynchronously:
  - EN1HZ=0, CLR=0, RUNNING=0, state STOP, prescaler=0.
  - Debounce counters=0; synchroniser and stable key registers=1 (released).
- Deassertion of RST takes effect at the next CLK edge.
- Synchroniser: 2 flip-flops per key. Nothing downstream of them samples a raw key.
- Debounce, per key:
  - If the synchronised value equals the stable value, the counter clears.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1 while still differing, stable takes the synchronised value and the counter clears.
  - Counter width is $clog2(DEB_CYCLES+1).
- Press event: a one-cycle internal pulse, registered at the same edge where stable goes 1→0.
  - Release (0→1) generates nothing.
  - A held key generates exactly one event.
  - A glitch shorter than DEB_CYCLES generates nothing.
- FSM states: STOP, RUN.
  - STOP + SS event → RUN.
  - RUN + SS event → STOP.
  - CLR event, any state → STOP, CLR=1 for one cycle, prescaler=0.
  - SS and CLR events in the same cycle: CLR wins; state goes to STOP; SS is ignored.
- Prescaler, width $clog2(DIV):
  - In RUN it increments.
  - At DIV-1 it wraps to 0 and EN1HZ=1 for that one cycle.
  - In STOP it holds its value (phase retained).
- Terminal count in the same cycle as an SS event in RUN: EN1HZ still fires (decision uses the current state), then the FSM stops.
- Terminal count in the same cycle as a CLR event: EN1HZ is suppressed.
- All outputs are registered; no combinational path from the keys to the outputs.
- Latency: raw key low sampled at edge k → press event at edge k+1+DEB_CYCLES → RUNNING/CLR update at edge k+2+DEB_CYCLES.
- First EN1HZ after a start from prescaler=0: DIV cycles after RUNNING rises.
- Reset mid-operation: all state is lost. A key held through reset deassertion produces one press event after debounce, because stable restarts at 1.

Test Plan (DIV=10, DEB_CYCLES=4 unless stated):
- Reset → RUNNING=0, CLR=0, EN1HZ=0. Idle 100 cycles → no pulses.
- KEY_SS low for 20 cycles, then high:
  - RUNNING rises exactly 6 edges after the first sampling edge.
  - EN1HZ pulses every 10 cycles, the first 10 cycles after RUNNING rises.
  - Release causes no toggle.
- Bounce: KEY_SS low for 3 cycles, high for 2, repeated 5 times, then held high → no state change.
- Pause/resume:
  - Stop when prescaler=6. Wait 50 cycles, restart.
  - First EN1HZ arrives 4 cycles after RUNNING rises; no EN1HZ while stopped.
- Clear:
  - KEY_CLR press in RUN → CLR=1 for exactly one cycle, RUNNING=0, prescaler=0.
  - SS and CLR pressed on the same cycle from STOP → CLR pulse, RUNNING stays 0.
- Async reset:
  - RST=0 mid-cycle while RUN with prescaler=7 → outputs 0 before the next CLK edge.
  - After release, no EN1HZ until restarted.
